// File: rtl/spec_rotator_pkg.sv
// Shared definitions for the quarter-rate spectrum rotator: mode codes,
// FSM states and the saturating/wrapping negate helper.
`timescale 1ns/1ps
package spec_rot_pkg;

  localparam logic [1:0] MODE_BYP = 2'd0;
  localparam logic [1:0] MODE_P4  = 2'd1;
  localparam logic [1:0] MODE_INV = 2'd2;
  localparam logic [1:0] MODE_M4  = 2'd3;

  // Widest rail the negate helper supports; callers sign-extend in and truncate out.
  localparam int unsigned NEG_MAXW = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    EXPECT
  } state_t;

  function automatic logic [NEG_MAXW-1:0] sat_neg(input logic [NEG_MAXW-1:0] x,
                                                  input int unsigned          w,
                                                  input bit                   sat);
    logic [NEG_MAXW-1:0] min_v;
    min_v = '1 << (w - 1);
    if (sat && (x == min_v)) return ~min_v;
    return -x;
  endfunction

endpackage

// File: rtl/spec_rotator_if.sv
// Sample-stream bundle between the rotator and its neighbours.
`timescale 1ns/1ps
interface spec_rotator_if #(parameter int unsigned W = 20);

  logic                en;
  logic                in_sop;
  logic signed [W-1:0] in_i;
  logic signed [W-1:0] in_q;
  logic [1:0]          mode;
  logic signed [W-1:0] out_i;
  logic signed [W-1:0] out_q;
  logic                out_valid;
  logic                out_sop;
  logic                out_eop;
  logic                sop_err;

  modport master (
    output en, in_sop, in_i, in_q, mode,
    input  out_i, out_q, out_valid, out_sop, out_eop, sop_err
  );

  modport slave (
    input  en, in_sop, in_i, in_q, mode,
    output out_i, out_q, out_valid, out_sop, out_eop, sop_err
  );

endinterface

// File: rtl/spec_rotator_cplx_rot90.sv
// Combinational multiply of a complex sample by j^k, k in 0..3.
`timescale 1ns/1ps
module cplx_rot90
  import spec_rot_pkg::*;
#(
  parameter int unsigned W   = 20,
  parameter bit          SAT = 1'b1
) (
  input  logic [1:0]          k_i,
  input  logic signed [W-1:0] i_i,
  input  logic signed [W-1:0] q_i,
  output logic signed [W-1:0] i_o,
  output logic signed [W-1:0] q_o
);

  always_comb begin
    i_o = i_i;
    q_o = q_i;
    case (k_i)
      2'd1: begin
        i_o = W'(sat_neg(NEG_MAXW'(q_i), W, SAT));
        q_o = i_i;
      end
      2'd2: begin
        i_o = W'(sat_neg(NEG_MAXW'(i_i), W, SAT));
        q_o = W'(sat_neg(NEG_MAXW'(q_i), W, SAT));
      end
      2'd3: begin
        i_o = q_i;
        q_o = W'(sat_neg(NEG_MAXW'(i_i), W, SAT));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/spec_rotator.sv
// Symbol-aware rotator: applies j^(m*n) per sample, restarts phase on SOP,
// generates EOP after NFFT samples and flags framing errors.
`timescale 1ns/1ps
module spec_rotator
  import spec_rot_pkg::*;
#(
  parameter int unsigned W    = 20,
  parameter int unsigned NFFT = 1024,
  parameter bit          SAT  = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  spec_rotator_if.slave  bus
);

  localparam int unsigned NW = $clog2(NFFT);

  state_t              state_q;
  logic [NW-1:0]       n_q, n_d;
  logic [1:0]          mode_q, mode_d;
  logic [1:0]          k;
  logic                last;
  logic signed [W-1:0] rot_i, rot_q;
  logic signed [W-1:0] out_i_q, out_q_q;
  logic                out_valid_q, out_sop_q, out_eop_q, sop_err_q;

  // Phase is derived from the index/mode this sample will carry, so SOP samples
  // see n=0 with the freshly presented mode.
  always_comb begin
    mode_d = bus.in_sop ? bus.mode : mode_q;
    n_d    = bus.in_sop ? '0 : n_q + 1'b1;
    last   = (n_d == NW'(NFFT - 1));
    k      = 2'd0;
    case (mode_d)
      MODE_BYP: k = 2'd0;
      MODE_P4:  k = n_d[1:0];
      MODE_INV: k = {n_d[0], 1'b0};
      MODE_M4:  k = 2'd0 - n_d[1:0];
      default:  k = 2'd0;
    endcase
  end

  cplx_rot90 #(.W(W), .SAT(SAT)) u_rot (
    .k_i (k),
    .i_i (bus.in_i),
    .q_i (bus.in_q),
    .i_o (rot_i),
    .q_o (rot_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      mode_q      <= '0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      sop_err_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      sop_err_q   <= 1'b0;
      if (bus.en) begin
        if (bus.in_sop) begin
          // SOP restarts a symbol from any state; inside RUN it is an early SOP.
          sop_err_q   <= (state_q == RUN);
          state_q     <= RUN;
          mode_q      <= mode_d;
          n_q         <= n_d;
          out_valid_q <= 1'b1;
          out_sop_q   <= 1'b1;
          out_i_q     <= rot_i;
          out_q_q     <= rot_q;
        end else begin
          case (state_q)
            RUN: begin
              n_q         <= n_d;
              out_valid_q <= 1'b1;
              out_i_q     <= rot_i;
              out_q_q     <= rot_q;
              if (last) begin
                out_eop_q <= 1'b1;
                state_q   <= EXPECT;
              end
            end
            EXPECT: begin
              sop_err_q <= 1'b1;
              state_q   <= IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.out_i     = out_i_q;
  assign bus.out_q     = out_q_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.sop_err   = sop_err_q;

endmodule

// File: tb/tb_spec_rotator.sv
// Scoreboard bench: a saturating and a wrapping rotator share one stimulus
// stream; expectations come from complex arithmetic on integers.
`timescale 1ns/1ps
module tb_spec_rotator;

  localparam int W    = 20;
  localparam int NFFT = 8;
  localparam int MAXV = (1 << (W - 1)) - 1;
  localparam int MINV = -(1 << (W - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spec_rotator_if #(.W(W)) sif ();
  spec_rotator_if #(.W(W)) wif ();

  spec_rotator #(.W(W), .NFFT(NFFT), .SAT(1'b1)) dut_s (.clk(clk), .rst(rst), .bus(sif.slave));
  spec_rotator #(.W(W), .NFFT(NFFT), .SAT(1'b0)) dut_w (.clk(clk), .rst(rst), .bus(wif.slave));

  typedef struct {
    bit valid, sop, eop, err;
    int si, sq, wi, wq;
  } exp_t;

  exp_t q_exp[$];
  int checks   = 0;
  int failures = 0;

  // Reference model state: 0 idle, 1 inside a symbol, 2 awaiting next SOP
  int m_state = 0;
  int m_n     = 0;
  int m_mode  = 0;
  int last_si = 0, last_sq = 0, last_wi = 0, last_wq = 0;
  int mon_si = 0, mon_sq = 0, mon_wi = 0, mon_wq = 0;

  function automatic void check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int fit(int v, bit sat);
    if (v > MAXV) return sat ? MAXV : v - (1 << W);
    return v;
  endfunction

  function automatic void emit(int i, int q, bit sop, bit eop, bit err);
    int cs[4];
    int sn[4];
    int k, re, im;
    exp_t e;
    cs = '{1, 0, -1, 0};
    sn = '{0, 1, 0, -1};
    k  = (m_mode * m_n) % 4;
    re = i * cs[k] - q * sn[k];
    im = i * sn[k] + q * cs[k];
    e.valid = 1'b1; e.sop = sop; e.eop = eop; e.err = err;
    e.si = fit(re, 1'b1); e.sq = fit(im, 1'b1);
    e.wi = fit(re, 1'b0); e.wq = fit(im, 1'b0);
    last_si = e.si; last_sq = e.sq; last_wi = e.wi; last_wq = e.wq;
    q_exp.push_back(e);
  endfunction

  task automatic drive(bit e, bit s, int i, int q, int m);
    exp_t x;
    sif.en = e; sif.in_sop = s; sif.in_i = W'(i); sif.in_q = W'(q); sif.mode = 2'(m);
    wif.en = e; wif.in_sop = s; wif.in_i = W'(i); wif.in_q = W'(q); wif.mode = 2'(m);
    if (e) begin
      if (s) begin
        x.err = (m_state == 1);
        m_mode = m; m_n = 0;
        emit(i, q, 1'b1, 1'b0, x.err);
        m_state = 1;
      end else if (m_state == 1) begin
        m_n++;
        emit(i, q, 1'b0, m_n == NFFT - 1, 1'b0);
        if (m_n == NFFT - 1) m_state = 2;
      end else if (m_state == 2) begin
        x.valid = 1'b0; x.sop = 1'b0; x.eop = 1'b0; x.err = 1'b1;
        x.si = last_si; x.sq = last_sq; x.wi = last_wi; x.wq = last_wq;
        q_exp.push_back(x);
        m_state = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // SOP with mode m, then n-1 further samples presenting a different mode.
  task automatic sym(int m, int i, int q, int n);
    drive(1'b1, 1'b1, i, q, m);
    for (int j = 1; j < n; j++) drive(1'b1, 1'b0, i, q, (m + 1) % 4);
  endtask

  function automatic int rnd();
    if ($urandom % 8 == 0) return MINV;
    return int'($urandom_range(MAXV - MINV)) + MINV;
  endfunction

  task automatic check_zero(string tag);
    check({tag, "_s_valid"}, int'(sif.out_valid), 0);
    check({tag, "_s_sop"},   int'(sif.out_sop), 0);
    check({tag, "_s_eop"},   int'(sif.out_eop), 0);
    check({tag, "_s_err"},   int'(sif.sop_err), 0);
    check({tag, "_s_i"},     int'(sif.out_i), 0);
    check({tag, "_s_q"},     int'(sif.out_q), 0);
    check({tag, "_w_valid"}, int'(wif.out_valid), 0);
    check({tag, "_w_i"},     int'(wif.out_i), 0);
    check({tag, "_w_q"},     int'(wif.out_q), 0);
  endtask

  always @(posedge rst) begin
    mon_si = 0; mon_sq = 0; mon_wi = 0; mon_wq = 0;
  end

  // Monitor: pops an expectation whenever the DUT presents something.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sif.out_valid || sif.sop_err) begin
          if (q_exp.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_output actual=valid%0d/err%0d required=none at %0t",
                     sif.out_valid, sif.sop_err, $time);
          end else begin
            e = q_exp.pop_front();
            check("s_valid", int'(sif.out_valid), int'(e.valid));
            check("s_sop",   int'(sif.out_sop),   int'(e.sop));
            check("s_eop",   int'(sif.out_eop),   int'(e.eop));
            check("s_err",   int'(sif.sop_err),   int'(e.err));
            check("s_i",     int'(sif.out_i), e.si);
            check("s_q",     int'(sif.out_q), e.sq);
            check("w_valid", int'(wif.out_valid), int'(e.valid));
            check("w_err",   int'(wif.sop_err),   int'(e.err));
            check("w_i",     int'(wif.out_i), e.wi);
            check("w_q",     int'(wif.out_q), e.wq);
            mon_si = e.si; mon_sq = e.sq; mon_wi = e.wi; mon_wq = e.wq;
          end
        end else begin
          check("idle_s_sop",  int'(sif.out_sop), 0);
          check("idle_s_eop",  int'(sif.out_eop), 0);
          check("idle_w_valid", int'(wif.out_valid), 0);
          check("hold_s_i", int'(sif.out_i), mon_si);
          check("hold_s_q", int'(sif.out_q), mon_sq);
          check("hold_w_i", int'(wif.out_i), mon_wi);
          check("hold_w_q", int'(wif.out_q), mon_wq);
        end
      end
    end
  end

  initial begin
    sif.en = 1'b0; sif.in_sop = 1'b0; sif.in_i = '0; sif.in_q = '0; sif.mode = '0;
    wif.en = 1'b0; wif.in_sop = 1'b0; wif.in_i = '0; wif.in_q = '0; wif.mode = '0;
    #2;
    check_zero("reset");
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // Alternating inversion, then +fs/4 and -fs/4 phase walks
    sym(2, 100, 50, NFFT);
    sym(1, 10, 0, NFFT);
    sym(3, 10, 0, NFFT);

    // Negating the most negative value at n=1
    drive(1'b1, 1'b1, 1, 1, 2);
    drive(1'b1, 1'b0, MINV, MINV, 2);
    for (int j = 2; j < NFFT; j++) drive(1'b1, 1'b0, MINV, 7, 0);

    // Early SOP at n=5 switching to bypass
    sym(2, 300, -200, 5);
    sym(0, 300, -200, NFFT);

    // Non-SOP after EOP, then dropped samples in IDLE
    drive(1'b1, 1'b0, 5, 6, 1);
    drive(1'b1, 1'b0, 7, 8, 1);
    drive(1'b1, 1'b0, 9, 9, 1);
    drive(1'b0, 1'b0, 0, 0, 0);

    // Enable gap mid-symbol
    drive(1'b1, 1'b1, 40, 30, 1);
    drive(1'b1, 1'b0, 40, 30, 1);
    drive(1'b1, 1'b0, 41, 31, 1);
    for (int j = 0; j < 3; j++) drive(1'b0, 1'b0, 999, 999, 2);
    for (int j = 3; j < NFFT; j++) drive(1'b1, 1'b0, 42 + j, -j, 0);

    // Reset mid-symbol
    drive(1'b1, 1'b1, 77, 66, 3);
    drive(1'b1, 1'b0, 77, 66, 3);
    drive(1'b1, 1'b0, 77, 66, 3);
    sif.en = 1'b0; wif.en = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_zero("midrst");
    check("q_empty_at_rst", q_exp.size(), 0);
    m_state = 0; m_n = 0; m_mode = 0;
    last_si = 0; last_sq = 0; last_wi = 0; last_wq = 0;
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    sym(1, 12, -34, NFFT);

    // Randomised traffic, mid-symbol mode changes included
    for (int c = 0; c < 1500; c++) begin
      bit e, s;
      e = ($urandom % 5) != 0;
      s = (m_state == 2) ? (($urandom % 4) != 0) : (($urandom % 12) == 0);
      drive(e, s, rnd(), rnd(), int'($urandom % 4));
    end

    drive(1'b0, 1'b0, 0, 0, 0);
    for (int t = 0; t < 20 && q_exp.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    check("drain_queue_empty", q_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spec_rotator.md
Name: spec_rotator

Overview:
Parametrised quarter-rate spectrum rotator for the OFDM CP/time-domain path. It multiplies each complex sample by j^(m·n), where n is the sample index within the symbol and m is the per-symbol mode. The modes are bypass, +fs/4, fs/2 (spectrum inversion) and -fs/4. The block is symbol-aware: the phase restarts on each SOP, it flags framing errors, and it generates EOP.

Parameters:
W, 20, sample width per rail, signed two's complement
NFFT, 1024, samples per symbol (power of two, ≥4)
SAT, 1, 1 = saturating negation, 0 = wrapping negation

Ports:
clk  in  1  clock
rst  in  1  reset
en  in  1  input sample valid
in_sop  in  1  first sample of symbol, qualified by en
in_i  in  W  signed I sample
in_q  in  W  signed Q sample
mode  in  2  rotation mode, sampled only on the SOP sample
out_i  out  W  rotated I
out_q  out  W  rotated Q
out_valid  out  1  output sample valid
out_sop  out  1  first output sample of symbol
out_eop  out  1  last output sample of symbol (index NFFT-1)
sop_err  out  1  one-cycle framing-error pulse

Behaviour:
- Reset rst is asynchronous and active-high; clock is clk.
- On reset: all outputs are 0, FSM is IDLE, idx=0, active mode=0.
- Mode encoding:
  - 0: bypass, k=0
  - 1: k = n mod 4
  - 2: k = 2n mod 4
  - 3: k = 3n mod 4
- Rotation by k:
  - 0 → (i, q)
  - 1 → (-q, i)
  - 2 → (-i, -q)
  - 3 → (q, -i)
- Negation:
  - SAT=1: -(-2^(W-1)) yields 2^(W-1)-1.
  - SAT=0: wraps; -(-2^(W-1)) = -2^(W-1).
  - No other width growth.
- Latency: exactly 1 clk from an en sample to its out_valid. Only en=1 cycles advance state.
- When no sample is emitted: out_valid=0, out_i/out_q hold their last value, and out_sop/out_eop are 0.
- FSM states:
  - IDLE: en samples without in_sop are dropped (out_valid=0). An en sample with in_sop latches mode, sets n=0, emits the sample with out_sop=1, and moves to RUN.
  - RUN: each en sample increments n. The sample with n=NFFT-1 is emitted with out_eop=1, and the FSM moves to EXPECT.
  - EXPECT:
    - en with in_sop: start a new symbol as in IDLE.
    - en without in_sop: drop the sample, pulse sop_err, go to IDLE.
- SOP in RUN before n reaches NFFT-1 (early SOP): pulse sop_err in the same cycle as that sample's output. Resync: latch the new mode, n=0, emit the sample with out_sop=1, and stay in RUN.
- NFFT=4 with mode 1: the phase pattern k = 0,1,2,3 repeats identically each symbol.
- A mode change outside the SOP sample has no effect until the next SOP.
- Reset during a symbol aborts it immediately. No out_eop is generated for the partial symbol.
- out_sop and out_eop are never both 1, because NFFT≥4.

Decomposition:
- Shared package spec_rot_pkg holds:
  - mode constants MODE_BYP=0, MODE_P4=1, MODE_INV=2, MODE_M4=3
  - FSM state enum IDLE/RUN/EXPECT
  - function sat_neg(x, W, SAT)
- Sub-module cplx_rot90: a combinational rotate-by-k with saturating negate, parametrised by W and SAT, instantiated once.
- The top holds the FSM, the index counter, mode latching, and the output register.

Test Plan:
- NFFT=8, mode=2, SOP then samples (i,q)=(100,50) ×8 → out_valid at cycle+1. Outputs alternate (100,50),(-100,-50), …; out_sop on sample 0; out_eop on sample 7.
- mode=1, constant (10,0) for 4 samples → outputs (10,0),(0,10),(-10,0),(0,-10). Mode=3 on the same stimulus → (10,0),(0,-10),(-10,0),(0,10).
- SAT=1, mode=2, sample index 1 = (-524288,-524288) → output (524287,524287). SAT=0 → (-524288,-524288).
- Early SOP at n=5 with mode switching 2→0 → sop_err pulse; out_sop=1 on that sample; subsequent outputs unrotated, with out_eop 8 samples later.
- After EOP, a non-SOP en sample → sop_err=1, out_valid=0. The block remains in IDLE and drops samples until the next in_sop.
- en gaps mid-symbol (en=0 for 3 cycles) → out_valid=0 and outputs held; the phase index continues from its pre-gap value. Assert rst mid-symbol → all outputs 0 asynchronously; the next SOP starts cleanly.
